// File: rtl/zx_timing_pkg.sv
// Shared Spectrum frame-timing constants and the /INT state encoding.
package zx_timing_pkg;

  localparam int ZX_PERIOD_48   = 69888;
  localparam int ZX_PERIOD_128  = 70908;
  localparam int ZX_PULSE_TICKS = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ASSERT = 1'b1
  } int_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zx_tstate_counter.sv
// Wrapping T-state counter with a per-frame period register; the frame
// length only changes at the wrap so a mode switch never splits a frame.
module zx_tstate_counter
  import zx_timing_pkg::*;
#(
  parameter int PERIOD_48  = ZX_PERIOD_48,
  parameter int PERIOD_128 = ZX_PERIOD_128,
  parameter int CNT_W      = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_128k,
  output logic [CNT_W-1:0] tstate,
  output logic             frame_wrap
);

  logic [CNT_W-1:0] tstate_q, tstate_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             last_tick;

  always_comb begin
    last_tick = (tstate_q == (period_q - CNT_W'(1)));
    tstate_d  = tstate_q + CNT_W'(1);
    period_d  = period_q;
    if (last_tick) begin
      tstate_d = '0;
      period_d = mode_128k ? CNT_W'(PERIOD_128) : CNT_W'(PERIOD_48);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tstate_q <= '0;
      period_q <= CNT_W'(PERIOD_48);
    end else begin
      tstate_q <= tstate_d;
      period_q <= period_d;
    end
  end

  assign tstate     = tstate_q;
  assign frame_wrap = (tstate_q == '0);

endmodule

// File: rtl/zx_int_gen.sv
// Frame interrupt generator: drives Z80 /INT once per frame (fixed pulse or
// held until acknowledge), plus frame strobe, frame counter and FLASH phase.
module zx_int_gen
  import zx_timing_pkg::*;
#(
  parameter int PERIOD_48   = ZX_PERIOD_48,
  parameter int PERIOD_128  = ZX_PERIOD_128,
  parameter int CNT_W       = 17,
  parameter int ACK_MODE    = 0,
  parameter int PULSE_TICKS = ZX_PULSE_TICKS,
  parameter int MAX_HOLD    = 32,
  parameter int FLASH_LOG2  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             int_en,
  input  logic             mode_128k,
  input  logic             m1_n,
  input  logic             iorq_n,
  output logic             int_n,
  output logic             frame_start,
  output logic [CNT_W-1:0] tstate,
  output logic [7:0]       frame_cnt,
  output logic             flash
);

  localparam int HOLD_MAX = max_int(PULSE_TICKS, MAX_HOLD);
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] PULSE_LAST = HOLD_W'(PULSE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);

  int_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              int_n_q, int_n_d;
  logic              frame_start_q, frame_start_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              frame_wrap;
  logic              ack;
  logic              release_hit;

  zx_tstate_counter #(
    .PERIOD_48  (PERIOD_48),
    .PERIOD_128 (PERIOD_128),
    .CNT_W      (CNT_W)
  ) u_tstate (
    .clk        (clk),
    .reset      (reset),
    .mode_128k  (mode_128k),
    .tstate     (tstate),
    .frame_wrap (frame_wrap)
  );

  // Acknowledges only matter in hold mode; dropping int_en always releases.
  always_comb begin
    ack         = !m1_n && !iorq_n;
    release_hit = !int_en ||
                  ((ACK_MODE == 0) ? (hold_cnt_q == PULSE_LAST)
                                   : (ack || (hold_cnt_q == HOLD_LAST)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_wrap && int_en) state_d = ASSERT;
      ASSERT:  if (release_hit)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_n_d       = int_n_q;
    hold_cnt_d    = hold_cnt_q;
    frame_start_d = frame_wrap;
    frame_cnt_d   = frame_cnt_q + 8'(frame_wrap);
    case (state_q)
      IDLE: begin
        if (state_d == ASSERT) begin
          int_n_d    = 1'b0;
          hold_cnt_d = '0;
        end
      end
      ASSERT: begin
        if (state_d == IDLE) int_n_d    = 1'b1;
        else                 hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      default: int_n_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q    <= '0;
      int_n_q       <= 1'b1;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      int_n_q       <= int_n_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign int_n       = int_n_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign flash       = frame_cnt_q[FLASH_LOG2];

endmodule
